// File: rtl/led_pattern_sequencer.sv
// LED bank sequencer: solid / blink / chase / count frames stepped every PRESCALE clocks.
// Optional macro LED_PWM_EN adds a 4-bit brightness input with 15-step PWM dimming of led.
module led_pattern_sequencer #(
    parameter int PRESCALE = 25000000,
    parameter int LED_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [LED_W-1:0] cmd_pattern,
    input  logic [7:0]       cmd_reps,
    input  logic             abort,
`ifdef LED_PWM_EN
    input  logic [3:0]       brightness,
`endif
    output logic [LED_W-1:0] led,
    output logic             busy,
    output logic             done
);

    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {MODE_SOLID, MODE_BLINK, MODE_CHASE, MODE_COUNT} mode_t;

    state_t           state_reg, state_next;
    mode_t            mode_reg, mode_next;
    logic [LED_W-1:0] pattern_reg, pattern_next;
    logic [7:0]       reps_reg, reps_next;
    logic [7:0]       step_reg, step_next, step_inc;
    logic             phase_reg, phase_next;
    logic [PW-1:0]    presc_reg, presc_next;
    logic [LED_W-1:0] frame_reg, frame_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             tick;
    logic [LED_W-1:0] frame_rot;

    // Rotate-left-by-one of the current frame: MSB wraps into bit 0.
    generate
        for (genvar gi = 0; gi < LED_W; gi++) begin : g_rot
            assign frame_rot[gi] = frame_reg[(gi + LED_W - 1) % LED_W];
        end
    endgenerate

    assign step_inc  = step_reg + 8'd1;
    assign cmd_ready = (state_reg == IDLE);
    assign busy      = busy_reg;
    assign done      = done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            mode_reg    <= MODE_SOLID;
            pattern_reg <= '0;
            reps_reg    <= '0;
            step_reg    <= '0;
            phase_reg   <= 1'b0;
            presc_reg   <= '0;
            frame_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mode_reg    <= mode_next;
            pattern_reg <= pattern_next;
            reps_reg    <= reps_next;
            step_reg    <= step_next;
            phase_reg   <= phase_next;
            presc_reg   <= presc_next;
            frame_reg   <= frame_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        mode_next    = mode_reg;
        pattern_next = pattern_reg;
        reps_next    = reps_reg;
        step_next    = step_reg;
        phase_next   = phase_reg;
        presc_next   = presc_reg;
        frame_next   = frame_reg;
        done_next    = 1'b0;
        tick         = 1'b0;

        case (state_reg)
            IDLE: begin
                presc_next = '0;
                if (cmd_valid) begin
                    mode_next    = mode_t'(cmd_mode);
                    pattern_next = cmd_pattern;
                    reps_next    = cmd_reps;
                    step_next    = '0;
                    phase_next   = 1'b0;
                    frame_next   = cmd_pattern;
                    state_next   = RUN;
                end
            end
            RUN: begin
                tick = (presc_reg == PS_LAST);
                // abort wins over a tick landing on the same edge
                if (abort) begin
                    state_next = IDLE;
                    frame_next = '0;
                    presc_next = '0;
                end else if (tick) begin
                    presc_next = '0;
                    step_next  = step_inc;
                    case (mode_reg)
                        MODE_SOLID: frame_next = frame_reg;
                        MODE_BLINK: begin
                            phase_next = ~phase_reg;
                            frame_next = phase_reg ? pattern_reg : '0;
                        end
                        MODE_CHASE: frame_next = frame_rot;
                        MODE_COUNT: frame_next = frame_reg + LED_W'(1);
                    endcase
                    // reps == 0 means endless; the step counter just wraps
                    if ((reps_reg != 8'd0) && (step_inc == reps_reg)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end else begin
                    presc_next = presc_reg + PW'(1);
                end
            end
        endcase

        busy_next = (state_next == RUN);
    end

`ifdef LED_PWM_EN
    logic [3:0]       pwm_reg;
    logic [LED_W-1:0] led_reg;
    logic             pwm_on;

    // pwm_reg runs 0..14, so brightness 15 is always on and 0 always off
    assign pwm_on = (pwm_reg < brightness);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_reg <= '0;
            led_reg <= '0;
        end else begin
            pwm_reg <= (pwm_reg == 4'd14) ? 4'd0 : pwm_reg + 4'd1;
            led_reg <= frame_next & {LED_W{pwm_on}};
        end
    end

    assign led = led_reg;
`else
    assign led = frame_reg;
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: closed-form frame model plus directed literal checks.
module tb_led_pattern_sequencer;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_mode = 2'd0;
    logic [7:0] cmd_pattern = 8'h00;
    logic [7:0] cmd_reps = 8'd0;
    logic       abort = 1'b0;
    logic       cmd_ready;
    logic [7:0] led;
    logic       busy;
    logic       done;
`ifdef LED_PWM_EN
    logic [3:0] brightness = 4'hF;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    led_pattern_sequencer #(.PRESCALE(P), .LED_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mode    (cmd_mode),
        .cmd_pattern (cmd_pattern),
        .cmd_reps    (cmd_reps),
        .abort       (abort),
`ifdef LED_PWM_EN
        .brightness  (brightness),
`endif
        .led         (led),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Frame shown after k completed steps of a run.
    function automatic logic [7:0] frame_at(input logic [1:0] md, input logic [7:0] p, input int k);
        logic [15:0] d;
        case (md)
            2'd0: return p;
            2'd1: return ((k % 2) != 0) ? 8'h00 : p;
            2'd2: begin
                d = {p, p} << (k % 8);
                return d[15:8];
            end
            default: return p + 8'(k);
        endcase
    endfunction

    // Model: a run is just (accept cycle, mode, pattern, reps); the frame follows from elapsed time.
    int         cyc = 0;
    bit         m_run = 1'b0;
    int         acc = 0;
    logic [1:0] m_mode = 2'd0;
    logic [7:0] m_pat = 8'h00;
    logic [7:0] m_reps = 8'd0;
    logic [7:0] idle_led = 8'h00;
    int         done_at = -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run    <= 1'b0;
            idle_led <= 8'h00;
            done_at  <= -1;
        end else begin
            cyc <= cyc + 1;
            if (!m_run) begin
                if (cmd_valid) begin
                    m_run  <= 1'b1;
                    acc    <= cyc;
                    m_mode <= cmd_mode;
                    m_pat  <= cmd_pattern;
                    m_reps <= cmd_reps;
                    $display("cmd accepted cyc=%0d mode=%0d pattern=%02h reps=%0d",
                             cyc, cmd_mode, cmd_pattern, cmd_reps);
                end
            end else if (abort) begin
                m_run    <= 1'b0;
                idle_led <= 8'h00;
            end else if ((m_reps != 8'd0) && (cyc == acc + int'(m_reps) * P)) begin
                m_run    <= 1'b0;
                idle_led <= frame_at(m_mode, m_pat, int'(m_reps));
                done_at  <= cyc + 1;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_model();
        logic [7:0] el;
        el = m_run ? frame_at(m_mode, m_pat, (cyc - acc - 1) / P) : idle_led;
        cmp("model led", led, el);
        cmp("model busy", busy, m_run);
        cmp("model cmd_ready", cmd_ready, !m_run);
        cmp("model done", done, (!m_run && done_at == cyc));
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) check_model();
    endtask

    task automatic issue(input logic [1:0] md, input logic [7:0] p, input logic [7:0] r);
        cmd_valid   = 1'b1;
        cmd_mode    = md;
        cmd_pattern = p;
        cmd_reps    = r;
        tick();
        cmd_valid   = 1'b0;
    endtask

    initial begin
        // 1. reset state, checked before any clock edge
        #2;
        cmp("reset led", led, 8'h00);
        cmp("reset busy", busy, 1'b0);
        cmp("reset done", done, 1'b0);
        cmp("reset cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 2. chase 0x01, 3 steps
        issue(2'd2, 8'h01, 8'd3);
        cmp("chase f0", led, 8'h01);
        repeat (4) tick();
        cmp("chase f1", led, 8'h02);
        repeat (4) tick();
        cmp("chase f2", led, 8'h04);
        repeat (4) tick();
        cmp("chase f3", led, 8'h08);
        cmp("chase done", done, 1'b1);
        tick();
        cmp("chase busy after", busy, 1'b0);
        cmp("chase hold", led, 8'h08);

        // 3. count wrap through 0xFF
        issue(2'd3, 8'hFE, 8'd3);
        cmp("count f0", led, 8'hFE);
        repeat (4) tick();
        cmp("count f1", led, 8'hFF);
        repeat (4) tick();
        cmp("count f2", led, 8'h00);
        repeat (4) tick();
        cmp("count f3", led, 8'h01);
        cmp("count done", done, 1'b1);
        tick();

        // 4. endless blink, aborted on the edge of the 5th tick
        issue(2'd1, 8'hA5, 8'd0);
        cmp("blink f0", led, 8'hA5);
        repeat (4) tick();
        cmp("blink f1", led, 8'h00);
        repeat (4) tick();
        cmp("blink f2", led, 8'hA5);
        repeat (11) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cmp("abort led", led, 8'h00);
        cmp("abort ready", cmd_ready, 1'b1);
        cmp("abort done", done, 1'b0);
        tick();

        // 5. command held while busy, accepted in the done cycle
        issue(2'd2, 8'h01, 8'd2);
        cmd_valid   = 1'b1;
        cmd_mode    = 2'd0;
        cmd_pattern = 8'h3C;
        cmd_reps    = 8'd1;
        tick();
        cmp("busy ignores cmd", cmd_ready, 1'b0);
        repeat (7) tick();
        cmp("b2b done", done, 1'b1);
        cmp("b2b ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        cmp("b2b led", led, 8'h3C);
        cmp("b2b busy", busy, 1'b1);
        repeat (6) tick();

        // 6. asynchronous reset during step 2 of a count run
        issue(2'd3, 8'h10, 8'd0);
        repeat (8) tick();
        cmp("pre-reset led", led, 8'h12);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async rst led", led, 8'h00);
        cmp("async rst busy", busy, 1'b0);
        cmp("async rst ready", cmd_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        issue(2'd3, 8'h40, 8'd2);
        cmp("fresh f0", led, 8'h40);
        repeat (8) tick();
        cmp("fresh f2", led, 8'h42);
        cmp("fresh done", done, 1'b1);

        // randomized traffic, checked every cycle by the model
        repeat (2000) begin
            tick();
            cmd_valid   = ($urandom_range(0, 3) == 0);
            cmd_mode    = 2'($urandom_range(0, 3));
            cmd_pattern = 8'($urandom);
            cmd_reps    = 8'($urandom_range(0, 4));
            abort       = ($urandom_range(0, 40) == 0);
        end
        cmd_valid = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
